// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit front end for the data-memory port.
//
// Captures one load or store from the execute stage and stalls the core while it
// runs a valid/ready request and a response handshake with data memory. Loads come
// back aligned and sign/zero-extended on load_data. Stores go out lane-replicated
// with byte strobes. Misaligned accesses, illegal funct3 values and accesses that
// exceed TIMEOUT cycles in REQ+WAIT complete with a fault and never reach, or are
// withdrawn from, memory.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   load, store           instruction class (both high is treated as a load)
//   funct3                access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr, store_data      effective byte address, rs2 value
//   load_data             formatted load result, held until the next load or fault
//   done, fault           one-cycle completion pulse; fault is qualified by done
//   stall                 hold PC/pipeline while the access is in flight
//   mem_req_*             request channel (valid/ready, we, word addr, wdata, wstrb)
//   mem_rsp_valid/rdata   response channel; rsp_valid also acknowledges writes
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 255,  // 0 disables the timeout
  parameter int unsigned CNT_W   = 8     // TIMEOUT must be < 2**CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        fault,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       off_q;
  logic [2:0]       funct3_q;
  logic [31:0]      load_data_q;
  logic             done_q;
  logic             fault_q;
  logic             req_valid_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  logic        is_store;
  logic        acc_fault;
  logic        timeout_hit;
  logic [31:0] wdata_fmt;
  logic [3:0]  wstrb_fmt;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] rdata_fmt;

  // load wins when both load and store are asserted
  assign is_store = store & ~load;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // Access legality, decided from the live inputs while in IDLE.
  always_comb begin
    acc_fault = 1'b0;
    case (funct3)
      3'b000:  acc_fault = 1'b0;
      3'b001:  acc_fault = addr[0];
      3'b010:  acc_fault = |addr[1:0];
      3'b100:  acc_fault = is_store;
      3'b101:  acc_fault = is_store | addr[0];
      default: acc_fault = 1'b1;
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    wdata_fmt = store_data;
    wstrb_fmt = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_fmt = {4{store_data[7:0]}};
        wstrb_fmt = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata_fmt = {2{store_data[15:0]}};
        wstrb_fmt = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  // Load alignment and extension, using the captured offset and funct3.
  always_comb begin
    rbyte = mem_rdata[{off_q, 3'b000} +: 8];
    rhalf = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  rdata_fmt = {{24{rbyte[7]}}, rbyte};
      3'b100:  rdata_fmt = {24'h000000, rbyte};
      3'b001:  rdata_fmt = {{16{rhalf[15]}}, rhalf};
      3'b101:  rdata_fmt = {16'h0000, rhalf};
      default: rdata_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      off_q       <= '0;
      funct3_q    <= '0;
      load_data_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
    end else begin
      // done/fault are single-cycle pulses that coincide with StDone
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load || store) begin
            off_q    <= addr[1:0];
            funct3_q <= funct3;
            we_q     <= is_store;
            addr_q   <= {addr[31:2], 2'b00};
            wdata_q  <= wdata_fmt;
            wstrb_q  <= is_store ? wstrb_fmt : 4'b0000;
            if (acc_fault) begin
              state_q     <= StDone;
              done_q      <= 1'b1;
              fault_q     <= 1'b1;
              load_data_q <= '0;
            end else begin
              state_q     <= StReq;
              req_valid_q <= 1'b1;
              cnt_q       <= '0;
            end
          end
        end
        StReq: begin
          cnt_q <= cnt_q + 1'b1;
          // timeout takes priority over a same-cycle accept
          if (timeout_hit) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            fault_q     <= 1'b1;
            load_data_q <= '0;
            req_valid_q <= 1'b0;
          end else if (mem_req_ready) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
          end
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            state_q     <= StDone;
            done_q      <= 1'b1;
            fault_q     <= 1'b1;
            load_data_q <= '0;
          end else if (mem_rsp_valid) begin
            state_q <= StDone;
            done_q  <= 1'b1;
            if (!we_q) begin
              load_data_q <= rdata_fmt;
            end
          end
        end
        StDone: begin
          // never start a new access here; the core advances this cycle
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    case (state_q)
      StIdle:  stall = load | store;
      StDone:  stall = 1'b0;
      default: stall = 1'b1;
    endcase
  end

  assign load_data     = load_data_q;
  assign done          = done_q;
  assign fault         = fault_q;
  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Testbench for lsu_mem_port: directed and randomized accesses against a byte-level
// memory model; request and completion checks are queue-driven by DUT outputs.
module tb_lsu_mem_port;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_data;
  logic        done, stall, fault;
  logic        mem_req_valid, mem_req_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_port #(
    .TIMEOUT(T),
    .CNT_W  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .store        (store),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .load_data    (load_data),
    .done         (done),
    .stall        (stall),
    .fault        (fault),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  typedef struct {
    logic        fault;
    logic [31:0] ld;
    int unsigned cyc;
  } rsp_t;

  req_t        req_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] mem[256];
  logic [31:0] model_ld;
  int unsigned cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  logic        exp_stall = 1'b0, exp_rv = 1'b0, exp_done = 1'b0, exp_fault = 1'b0;
  req_t        mon_r;
  rsp_t        mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
  endtask

  function automatic logic noise();
    return ($urandom % 4) == 0;
  endfunction

  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Reference load result: pick the addressed bytes, extend arithmetically.
  function automatic logic [31:0] fmt_load(input logic [31:0] w, input int off,
                                           input logic [2:0] f);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'h0000_00ff;
    h = (w >> (8 * off)) & 32'h0000_ffff;
    case (f)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // Per-cycle control checks plus queue-driven request/completion checks.
  always @(negedge clk) begin
    #1;
    check("stall", 32'(stall), 32'(exp_stall));
    check("mem_req_valid", 32'(mem_req_valid), 32'(exp_rv));
    check("done", 32'(done), 32'(exp_done));
    check("fault", 32'(fault), 32'(exp_fault));
    if (mem_req_valid) begin
      check("req_expected", 32'(req_q.size() != 0), 32'd1);
      if (req_q.size() != 0) begin
        mon_r = req_q[0];
        check("mem_we", 32'(mem_we), 32'(mon_r.we));
        check("mem_addr", mem_addr, mon_r.addr);
        check("mem_wstrb", 32'(mem_wstrb), 32'(mon_r.wstrb));
        if (mon_r.we) check("mem_wdata", mem_wdata, mon_r.wdata);
        if (mem_req_ready) mon_r = req_q.pop_front();
      end
    end
    if (done) begin
      check("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
      if (rsp_q.size() != 0) begin
        mon_e = rsp_q.pop_front();
        check("done_fault", 32'(fault), 32'(mon_e.fault));
        check("load_data", load_data, mon_e.ld);
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load = 1'b0;
      store = 1'b0;
      mem_req_ready = noise();
      mem_rsp_valid = noise();
      mem_rdata = $urandom;
      exp_stall = 1'b0;
      exp_rv = 1'b0;
      exp_done = 1'b0;
      exp_fault = 1'b0;
    end
  endtask

  // rd: cycles the memory withholds ready; sdl: cycles between accept and response.
  task automatic do_access(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int rd, input int sdl);
    int          sz, off, d, req_end, start, idx;
    logic        is_st, flt, to;
    logic [31:0] wd, word;
    logic [3:0]  strb;
    req_t        r;
    rsp_t        e;
    @(negedge clk);
    start = int'(cyc);
    sz = size_of(f3);
    off = int'(a % 4);
    idx = int'((a / 4) % 256);
    is_st = st && !ld;
    flt = (sz == 0) ? 1'b1 : (((off % sz) != 0) || (is_st && f3[2]));
    to = !flt && (rd >= T || rd + 1 + sdl >= T);
    d = flt ? 1 : (to ? T + 2 : rd + sdl + 3);
    req_end = flt ? 0 : (rd >= T ? T + 1 : rd + 1);
    wd = (sz == 1) ? {4{sd[7:0]}} : (sz == 2) ? {2{sd[15:0]}} : sd;
    strb = is_st ? 4'(((1 << sz) - 1) << off) : 4'b0000;
    word = mem[idx];
    if (flt || to) model_ld = 32'd0;
    else if (!is_st) model_ld = fmt_load(word, off, f3);
    else begin
      for (int i = 0; i < 4; i++) if (strb[i]) mem[idx][8*i +: 8] = wd[8*i +: 8];
    end
    e.fault = flt || to;
    e.ld = model_ld;
    e.cyc = int'(start + d);
    rsp_q.push_back(e);
    if (!flt) begin
      r.we = is_st;
      r.addr = {a[31:2], 2'b00};
      r.wdata = wd;
      r.wstrb = strb;
      req_q.push_back(r);
    end
    for (int k = 0; k <= d; k++) begin
      if (k != 0) @(negedge clk);
      if (k == 0) begin
        load = ld;
        store = st;
        funct3 = f3;
        addr = a;
        store_data = sd;
      end else begin
        // captured values must not follow the live inputs after IDLE
        load = 1'($urandom);
        store = 1'($urandom);
        funct3 = 3'($urandom);
        addr = $urandom;
        store_data = $urandom;
      end
      mem_req_ready = (k >= 1 && k <= req_end) ? (k == rd + 1) : noise();
      mem_rsp_valid = (!flt && k > req_end && k < d) ? (k == rd + sdl + 2) : noise();
      mem_rdata = (k == rd + sdl + 2) ? word : $urandom;
      exp_stall = (k < d);
      exp_rv = (k >= 1 && k <= req_end);
      exp_done = (k == d);
      exp_fault = (k == d) && (flt || to);
    end
    if (!flt && rd >= T && req_q.size() != 0) r = req_q.pop_front();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_load_data"}, load_data, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fault"}, 32'(fault), 32'd0);
    check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_we"}, 32'(mem_we), 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    req_t        rr;
    logic        l, s;
    logic [2:0]  f;
    logic [31:0] a;
    int          sz, rd, sdl;
    rst_n = 1'b0;
    load = 1'b0;
    store = 1'b0;
    funct3 = 3'd0;
    addr = 32'd0;
    store_data = 32'd0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata = 32'd0;
    model_ld = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    repeat (3) @(negedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Directed cases
    mem[64] = 32'hDEAD_BEEF;
    do_access(1'b1, 1'b0, 3'b010, 32'h100, $urandom, 0, 0);
    mem[64] = 32'h80AA_5511;
    do_access(1'b1, 1'b0, 3'b000, 32'h103, $urandom, 1, 0);
    do_access(1'b1, 1'b0, 3'b100, 32'h103, $urandom, 0, 2);
    do_access(1'b1, 1'b0, 3'b001, 32'h102, $urandom, 0, 0);
    do_access(1'b1, 1'b0, 3'b101, 32'h102, $urandom, 2, 1);
    do_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 0, 1);
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234_5678, 5, 0);
    do_access(1'b1, 1'b0, 3'b010, 32'h102, $urandom, 0, 0);
    do_access(1'b1, 1'b0, 3'b011, 32'h100, $urandom, 0, 0);
    do_access(1'b0, 1'b1, 3'b100, 32'h100, $urandom, 0, 0);
    do_access(1'b1, 1'b1, 3'b010, 32'h104, $urandom, 0, 0);
    do_access(1'b1, 1'b0, 3'b010, 32'h108, $urandom, 20, 0);
    do_access(1'b0, 1'b1, 3'b010, 32'h10c, $urandom, 2, 6);
    do_access(1'b1, 1'b0, 3'b010, 32'h110, $urandom, 3, 3);
    idle(1);

    // Reset while waiting for a load response
    do_access(1'b1, 1'b0, 3'b010, 32'h100, $urandom, 0, 0);
    @(negedge clk);
    load = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h300; store_data = $urandom;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    exp_stall = 1'b1; exp_rv = 1'b0; exp_done = 1'b0; exp_fault = 1'b0;
    rr.we = 1'b0; rr.addr = 32'h300; rr.wdata = 32'd0; rr.wstrb = 4'b0000;
    req_q.push_back(rr);
    @(negedge clk);
    load = 1'b0; mem_req_ready = 1'b1; exp_rv = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0; exp_rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; exp_stall = 1'b0;
    #2;
    check_all_zero("midreset");
    model_ld = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    check("late_rsp_load_data", load_data, 32'd0);
    do_access(1'b1, 1'b0, 3'b010, 32'h104, $urandom, 0, 0);

    // Randomized accesses
    for (int i = 0; i < 150; i++) begin
      l = 1'($urandom);
      s = 1'($urandom);
      if (!l && !s) l = 1'b1;
      f = 3'($urandom);
      if ($urandom % 4 != 0) begin
        case ($urandom % 5)
          0: f = 3'd0;
          1: f = 3'd1;
          2: f = 3'd2;
          3: f = 3'd4;
          default: f = 3'd5;
        endcase
      end
      a = 32'($urandom_range(0, 1023));
      sz = size_of(f);
      if (sz != 0 && ($urandom % 4 != 0)) a = a & ~(32'(sz) - 32'd1);
      rd = ($urandom % 8 == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
      sdl = ($urandom % 8 == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 3));
      do_access(l, s, f, a, $urandom, rd, sdl);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);

    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
